// File: rtl/window_spill_fill_ctrl_pkg.sv
// Shared state encoding, save-area geometry and modulo window arithmetic
// for the window spill/fill controller.
package wsf_pkg;

  typedef enum logic [2:0] {
    IDLE, SP_RD, SP_MEM, FL_MEM, FL_WR, WIM_UPD, DONE
  } wsf_state_e;

  localparam int WIN_BYTES = 64;
  localparam int REG_BYTES = 4;

  function automatic logic [4:0] win_dec(input logic [4:0] i, input int n);
    return (i == 5'd0) ? 5'(n - 1) : i - 5'd1;
  endfunction

  function automatic logic [4:0] win_inc(input logic [4:0] i, input int n);
    return (32'(i) == 32'(n - 1)) ? 5'd0 : i + 5'd1;
  endfunction

endpackage

// File: rtl/window_spill_fill_ctrl_if.sv
// Data-memory port between the spill/fill controller (master) and memory (slave).
interface window_spill_fill_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/window_spill_fill_ctrl_wim_onehot_enc.sv
// WIM-to-index encoder: lowest set bit wins (zero mask gives 0), plus a
// one-hot flag over the implemented windows. Shared with the trap generator.
module wim_onehot_enc #(
  parameter int NWINDOWS = 4
) (
  input  logic [31:0] wim,
  output logic [4:0]  idx,
  output logic        onehot
);

  localparam logic [NWINDOWS-1:0] ONE = {{(NWINDOWS-1){1'b0}}, 1'b1};

  logic [NWINDOWS-1:0] w;
  logic                unused_wim;

  assign w          = wim[NWINDOWS-1:0];
  assign unused_wim = ^wim;

  always_comb begin
    idx = '0;
    for (int i = NWINDOWS - 1; i >= 0; i--) begin
      if (w[i]) idx = 5'(i);
    end
    onehot = (w != '0) && ((w & (w - ONE)) == '0);
  end

endmodule

// File: rtl/window_spill_fill_ctrl.sv
// Trap-side window spill/fill engine: moves one 16-register window between the
// register file and the save area, then rotates WIM. Option: WSF_WIM_CHECK_EN.
module window_spill_fill_ctrl
  import wsf_pkg::*;
#(
  parameter int          NWINDOWS     = 4,
  parameter logic [31:0] SAVE_BASE    = 32'h0000_1000,
  parameter int          REGS_PER_WIN = 16
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     overFlow,
  input  logic                     underFlow,
  input  logic [31:0]              wim_in,
  output logic [31:0]              wim_out,
  output logic                     wim_we,
  output logic [4:0]               rf_win,
  output logic [3:0]               rf_idx,
  output logic                     rf_re,
  input  logic [31:0]              rf_rdata,
  output logic                     rf_we,
  output logic [31:0]              rf_wdata,
  window_spill_fill_ctrl_if.master mem_bus,
  output logic                     busy,
  output logic                     done
`ifdef WSF_WIM_CHECK_EN
  , output logic                   err
`endif
);

  localparam logic [3:0] K_LAST = 4'(REGS_PER_WIN - 1);

  wsf_state_e  state;
  logic [4:0]  tgt;
  logic [3:0]  k;
  logic [31:0] new_wim;
  logic [31:0] wd_q;
  logic        wd_held;
  logic [4:0]  inv_idx;
  logic        inv_onehot;
  logic [4:0]  t_ov;
  logic        accept;

  function automatic logic [31:0] addr_of(input logic [4:0] t, input logic [3:0] r);
    return SAVE_BASE + 32'(t) * 32'(WIN_BYTES) + 32'(r) * 32'(REG_BYTES);
  endfunction

  wim_onehot_enc #(.NWINDOWS(NWINDOWS)) u_enc (
    .wim    (wim_in),
    .idx    (inv_idx),
    .onehot (inv_onehot)
  );

  assign t_ov = win_dec(inv_idx, NWINDOWS);

`ifdef WSF_WIM_CHECK_EN
  logic reject;
  assign accept = (overFlow | underFlow) & inv_onehot;
  assign reject = (overFlow | underFlow) & ~inv_onehot;
`else
  logic unused_onehot;
  assign accept        = overFlow | underFlow;
  assign unused_onehot = inv_onehot;
`endif

  // First SP_MEM cycle forwards the RF read data; later wait cycles replay the captured copy.
  assign mem_bus.mem_wdata = (mem_bus.mem_req && mem_bus.mem_we) ?
                             (wd_held ? wd_q : rf_rdata) : 32'd0;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state            <= IDLE;
      tgt              <= '0;
      k                <= '0;
      new_wim          <= '0;
      wd_q             <= '0;
      wd_held          <= 1'b0;
      wim_out          <= '0;
      wim_we           <= 1'b0;
      rf_win           <= '0;
      rf_idx           <= '0;
      rf_re            <= 1'b0;
      rf_we            <= 1'b0;
      rf_wdata         <= '0;
      mem_bus.mem_req  <= 1'b0;
      mem_bus.mem_we   <= 1'b0;
      mem_bus.mem_addr <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef WSF_WIM_CHECK_EN
      err              <= 1'b0;
`endif
    end else begin
      wim_we <= 1'b0;
      rf_re  <= 1'b0;
      rf_we  <= 1'b0;
      done   <= 1'b0;
`ifdef WSF_WIM_CHECK_EN
      err    <= (state == IDLE) && reject;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            k    <= '0;
            busy <= 1'b1;
            if (overFlow) begin
              tgt     <= t_ov;
              new_wim <= 32'd1 << t_ov;
              rf_re   <= 1'b1;
              rf_win  <= t_ov;
              rf_idx  <= '0;
              state   <= SP_RD;
            end else begin
              tgt              <= inv_idx;
              new_wim          <= 32'd1 << win_inc(inv_idx, NWINDOWS);
              mem_bus.mem_req  <= 1'b1;
              mem_bus.mem_we   <= 1'b0;
              mem_bus.mem_addr <= addr_of(inv_idx, 4'd0);
              state            <= FL_MEM;
            end
          end
        end
        SP_RD: begin
          mem_bus.mem_req  <= 1'b1;
          mem_bus.mem_we   <= 1'b1;
          mem_bus.mem_addr <= addr_of(tgt, k);
          wd_held          <= 1'b0;
          state            <= SP_MEM;
        end
        SP_MEM: begin
          if (!wd_held) begin
            wd_q    <= rf_rdata;
            wd_held <= 1'b1;
          end
          if (mem_bus.mem_ack) begin
            mem_bus.mem_req <= 1'b0;
            mem_bus.mem_we  <= 1'b0;
            if (k == K_LAST) begin
              wim_we  <= 1'b1;
              wim_out <= new_wim;
              state   <= WIM_UPD;
            end else begin
              k      <= k + 4'd1;
              rf_re  <= 1'b1;
              rf_win <= tgt;
              rf_idx <= k + 4'd1;
              state  <= SP_RD;
            end
          end
        end
        FL_MEM: begin
          if (mem_bus.mem_ack) begin
            mem_bus.mem_req <= 1'b0;
            rf_we           <= 1'b1;
            rf_win          <= tgt;
            rf_idx          <= k;
            rf_wdata        <= mem_bus.mem_rdata;
            state           <= FL_WR;
          end
        end
        FL_WR: begin
          if (k == K_LAST) begin
            wim_we  <= 1'b1;
            wim_out <= new_wim;
            state   <= WIM_UPD;
          end else begin
            k                <= k + 4'd1;
            mem_bus.mem_req  <= 1'b1;
            mem_bus.mem_we   <= 1'b0;
            mem_bus.mem_addr <= addr_of(tgt, k + 4'd1);
            state            <= FL_MEM;
          end
        end
        WIM_UPD: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_spill_fill_ctrl.sv
// Randomised self-checking bench for window_spill_fill_ctrl against a
// transaction-level model of one window transfer. Honours WSF_WIM_CHECK_EN.
`timescale 1ns/1ps
module tb_window_spill_fill_ctrl;

  localparam int          NW   = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        overFlow = 1'b0;
  logic        underFlow = 1'b0;
  logic [31:0] wim_in = '0;
  logic [31:0] wim_out;
  logic        wim_we;
  logic [4:0]  rf_win;
  logic [3:0]  rf_idx;
  logic        rf_re;
  logic [31:0] rf_rdata = '0;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        done;
`ifdef WSF_WIM_CHECK_EN
  logic        err;
`endif

  window_spill_fill_ctrl_if mem_bus();

  window_spill_fill_ctrl #(.NWINDOWS(NW), .SAVE_BASE(BASE), .REGS_PER_WIN(16)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .overFlow  (overFlow),
    .underFlow (underFlow),
    .wim_in    (wim_in),
    .wim_out   (wim_out),
    .wim_we    (wim_we),
    .rf_win    (rf_win),
    .rf_idx    (rf_idx),
    .rf_re     (rf_re),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .mem_bus   (mem_bus),
    .busy      (busy),
    .done      (done)
`ifdef WSF_WIM_CHECK_EN
    , .err     (err)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Environment: register file with one-cycle read latency, and save-area memory.
  logic [31:0] rfimg [NW][16];
  logic [31:0] memimg [NW*16];

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) & 32'd63);
  endfunction

  always @(posedge Clk) if (rf_re) rf_rdata <= rfimg[int'(rf_win) % NW][rf_idx];

  assign mem_bus.mem_rdata = memimg[word_of(mem_bus.mem_addr)];

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Model of the operation in flight (written by the stimulus only).
  int          op_id = 0;
  logic        op_active = 1'b0;
  logic        exp_over = 1'b0;
  int          exp_T = 0;
  logic [31:0] exp_wim = '0;
  int          trig_edge = 0;
  logic [31:0] exp_data [16];
  int          ack_mode = 0;
  logic [31:0] stall_addr = '0;
  int          stall_total = 0;

  // Ack generator: 0 = always, 1 = stall a chosen address N cycles, 2 = random.
  logic ack_val = 1'b1;
  int   ack_seen = 0;
  int   stall_used = 0;
  assign mem_bus.mem_ack = ack_val;

  always @(posedge Clk) begin
    #1;
    if (op_id != ack_seen) begin
      ack_seen   = op_id;
      stall_used = 0;
    end
    if (ack_mode == 0) ack_val = 1'b1;
    else if (ack_mode == 1) begin
      if (mem_bus.mem_req && mem_bus.mem_addr == stall_addr && stall_used < stall_total) begin
        ack_val    = 1'b0;
        stall_used = stall_used + 1;
      end else ack_val = 1'b1;
    end else ack_val = ($urandom_range(0, 3) != 0);
  end

  // Per-cycle compare of the DUT against the model.
  int          seen_id = 0;
  int          n_st = 0, n_wr = 0, stalls = 0, done_rel = -1, mon_rel = 0;
  logic [31:0] first_addr = '0, last_addr = '0, got_wim = '0;
  logic        hold_valid = 1'b0, hold_we = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;

  always @(negedge Clk) begin
    if (op_id != seen_id) begin
      seen_id    = op_id;
      n_st       = 0;
      n_wr       = 0;
      stalls     = 0;
      done_rel   = -1;
      got_wim    = '0;
      hold_valid = 1'b0;
    end
    if (!Clr) begin
      if (op_active) begin
        mon_rel = edge_cnt - trig_edge + 1;
        checkOutput("busy", busy, (mon_rel >= 1 && mon_rel <= 34 + stalls));
        checkOutput("wim_we", wim_we, (mon_rel == 33 + stalls));
        checkOutput("done", done, (mon_rel == 34 + stalls));
        if (wim_we) begin
          checkOutput("wim_out", wim_out, exp_wim);
          got_wim = wim_out;
        end
        if (done) done_rel = mon_rel;
        if (mem_bus.mem_req) begin
          if (hold_valid) begin
            checkOutput("hold_addr", mem_bus.mem_addr, hold_addr);
            checkOutput("hold_wdata", mem_bus.mem_wdata, hold_wdata);
            checkOutput("hold_we", mem_bus.mem_we, hold_we);
          end
          checkOutput("mem_we", mem_bus.mem_we, exp_over);
          if (mem_bus.mem_ack) begin
            checkOutput("mem_addr", mem_bus.mem_addr, BASE + 32'(exp_T) * 64 + 32'(n_st) * 4);
            if (exp_over) checkOutput("mem_wdata", mem_bus.mem_wdata, exp_data[n_st % 16]);
            if (n_st == 0) first_addr = mem_bus.mem_addr;
            last_addr  = mem_bus.mem_addr;
            n_st       = n_st + 1;
            hold_valid = 1'b0;
          end else begin
            stalls     = stalls + 1;
            hold_valid = 1'b1;
            hold_addr  = mem_bus.mem_addr;
            hold_wdata = mem_bus.mem_wdata;
            hold_we    = mem_bus.mem_we;
          end
        end else hold_valid = 1'b0;
        if (rf_we) begin
          checkOutput("rf_win", 32'(rf_win), 32'(exp_T));
          checkOutput("rf_idx", 32'(rf_idx), 32'(n_wr));
          checkOutput("rf_wdata", rf_wdata, exp_data[n_wr % 16]);
          n_wr = n_wr + 1;
        end
      end else begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_req", mem_bus.mem_req, 0);
        checkOutput("idle_wim_we", wim_we, 0);
        checkOutput("idle_done", done, 0);
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rst_wim_out", wim_out, 0);
    checkOutput("rst_wim_we", wim_we, 0);
    checkOutput("rst_rf_win", 32'(rf_win), 0);
    checkOutput("rst_rf_idx", 32'(rf_idx), 0);
    checkOutput("rst_rf_re", rf_re, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_wdata", rf_wdata, 0);
    checkOutput("rst_mem_req", mem_bus.mem_req, 0);
    checkOutput("rst_mem_we", mem_bus.mem_we, 0);
    checkOutput("rst_mem_addr", mem_bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_bus.mem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
  endtask

  // One window transfer. abort_at/poke_at count cycles after the trigger edge (0 = never).
  task automatic applyStimulus(input logic ov, input logic un, input logic [31:0] wim,
                               input int amode, input logic [31:0] saddr, input int sn,
                               input int abort_at, input int poke_at);
    int   inv, t, guard;
    logic found;
    inv   = 0;
    found = 1'b0;
    for (int b = 0; b < NW; b++) begin
      if (!found && wim[b]) begin
        inv   = b;
        found = 1'b1;
      end
    end
    exp_over = ov;
    if (ov) begin
      t       = (inv + NW - 1) % NW;
      exp_wim = 32'd1 << t;
    end else begin
      t       = inv;
      exp_wim = 32'd1 << ((inv + 1) % NW);
    end
    exp_T = t;
    for (int j = 0; j < 16; j++) begin
      if (ov) begin
        rfimg[t][j] = $urandom;
        exp_data[j] = rfimg[t][j];
      end else begin
        memimg[t*16 + j] = $urandom;
        exp_data[j]      = memimg[t*16 + j];
      end
    end
    ack_mode    = amode;
    stall_addr  = saddr;
    stall_total = sn;
    wim_in      = wim;
    overFlow    = ov;
    underFlow   = un;
    trig_edge   = edge_cnt + 1;
    op_id       = op_id + 1;
    op_active   = 1'b1;
    @(posedge Clk); #3;
    overFlow  = 1'b0;
    underFlow = 1'b0;
    wim_in    = $urandom;
    guard     = 0;
    while (!done && guard < 200) begin
      guard = guard + 1;
      if (guard == abort_at) begin
        Clr       = 1'b1;
        op_active = 1'b0;
        @(posedge Clk); #3;
        Clr = 1'b0;
        checkResetState();
        repeat (40) @(posedge Clk);
        #3;
        return;
      end
      if (guard == poke_at) begin
        overFlow  = 1'($urandom_range(0, 1));
        underFlow = ~overFlow;
      end else begin
        overFlow  = 1'b0;
        underFlow = 1'b0;
      end
      @(posedge Clk); #3;
    end
    overFlow  = 1'b0;
    underFlow = 1'b0;
    checkOutput("done_seen", done, 1);
    @(posedge Clk); #3;
    op_active = 1'b0;
    checkOutput("n_stores", 32'(n_st), 16);
    checkOutput("n_rf_writes", 32'(n_wr), ov ? 32'd0 : 32'd16);
    checkOutput("done_cycle", 32'(done_rel), 32'(34 + stalls));
    repeat (2) @(posedge Clk);
    #3;
  endtask

  initial begin
    for (int w = 0; w < NW; w++)
      for (int j = 0; j < 16; j++) begin
        rfimg[w][j]      = $urandom;
        memimg[w*16 + j] = $urandom;
      end
    repeat (3) @(posedge Clk);
    #3;
    Clr = 1'b0;
    checkResetState();
    @(posedge Clk); #3;

    $display("[TB] spill window 3");
    applyStimulus(1'b1, 1'b0, 32'h1, 0, '0, 0, 0, 0);
    checkOutput("spill_first_addr", first_addr, 32'h10C0);
    checkOutput("spill_last_addr", last_addr, 32'h10FC);
    checkOutput("spill_wim", got_wim, 32'h8);
    checkOutput("spill_done_rel", 32'(done_rel), 34);

    $display("[TB] fill window 3");
    applyStimulus(1'b0, 1'b1, 32'h8, 0, '0, 0, 0, 0);
    checkOutput("fill_first_addr", first_addr, 32'h10C0);
    checkOutput("fill_last_addr", last_addr, 32'h10FC);
    checkOutput("fill_wim", got_wim, 32'h1);

    $display("[TB] ack stall on k=5");
    applyStimulus(1'b1, 1'b0, 32'h1, 1, 32'h10D4, 3, 0, 0);
    checkOutput("stall_done_rel", 32'(done_rel), 37);
    checkOutput("stall_cycles", 32'(stalls), 3);

    $display("[TB] simultaneous triggers");
    applyStimulus(1'b1, 1'b1, 32'h4, 0, '0, 0, 0, 0);
    checkOutput("both_first_addr", first_addr, 32'h1040);
    checkOutput("both_wim", got_wim, 32'h2);

    $display("[TB] reset mid-spill then fresh spill");
    applyStimulus(1'b1, 1'b0, 32'h2, 0, '0, 0, 10, 0);
    applyStimulus(1'b1, 1'b0, 32'h2, 0, '0, 0, 0, 0);
    checkOutput("fresh_first_addr", first_addr, 32'h1000);
    checkOutput("fresh_wim", got_wim, 32'h1);

`ifdef WSF_WIM_CHECK_EN
    $display("[TB] non-one-hot WIM rejected");
    wim_in   = 32'h5;
    overFlow = 1'b1;
    @(posedge Clk); #3;
    overFlow = 1'b0;
    checkOutput("err_pulse", err, 1);
    checkOutput("err_busy", busy, 0);
    checkOutput("err_req", mem_bus.mem_req, 0);
    @(posedge Clk); #3;
    checkOutput("err_clear", err, 0);
    checkOutput("err_busy_after", busy, 0);
`else
    $display("[TB] zero and multi-bit WIM");
    applyStimulus(1'b0, 1'b1, 32'h0, 0, '0, 0, 0, 0);
    checkOutput("zero_wim_first_addr", first_addr, 32'h1000);
    checkOutput("zero_wim_new", got_wim, 32'h2);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF6, 0, '0, 0, 0, 0);
    checkOutput("multi_wim_first_addr", first_addr, 32'h1000);
    checkOutput("multi_wim_new", got_wim, 32'h1);
`endif

    $display("[TB] randomised transfers");
    for (int n = 0; n < 8; n++) begin
      logic        ov, un;
      logic [31:0] w;
      ov = 1'($urandom_range(0, 1));
      un = ov ? 1'($urandom_range(0, 1)) : 1'b1;
      w  = ($urandom & ~32'hF) | (32'd1 << $urandom_range(0, NW - 1));
      applyStimulus(ov, un, w, 2, '0, 0, 0, 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
